// File: rtl/cmd_frontend_pkg.sv
// Shared command type plus helpers and error-cause indices for the command front-end.
package cmd_frontend_pkg;

  typedef struct packed {
    logic [3:0]  op;
    logic [11:0] addr;
    logic [15:0] data;
  } cmd_t;

  // Source-id width; a single source still gets one bit so ports never collapse.
  function automatic int src_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int CF_ERR_PUSH_FULL = 0;
  localparam int CF_ERR_RD_EMPTY  = 1;
  localparam int CF_ERR_FIN_EMPTY = 2;
  localparam int CF_ERR_W         = 3;

endpackage

// File: rtl/cmd_frontend_sync_fifo.sv
// Show-ahead synchronous FIFO; push while full and pop while empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         i_clk,
  input  logic                         i_rstn,
  input  logic                         i_push,
  input  logic [WIDTH-1:0]             i_data,
  input  logic                         i_pop,
  output logic [WIDTH-1:0]             o_data,
  output logic                         o_full,
  output logic                         o_empty,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    cnt_q;
  logic             wr, rd;

  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign o_full  = (cnt_q == CW'(DEPTH));
  assign o_empty = (cnt_q == '0);
  assign o_count = cnt_q;
  assign wr      = i_push && !o_full;
  assign rd      = i_pop && !o_empty;
  assign o_data  = mem_q[rptr_q];

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (wr) wptr_q <= inc(wptr_q);
      if (rd) rptr_q <= inc(rptr_q);
      cnt_q <= cnt_q + CW'(wr) - CW'(rd);
    end
  end

  // Storage needs no reset: the head is only consumed while count is non-zero.
  always_ff @(posedge i_clk) begin
    if (wr) mem_q[wptr_q] <= i_data;
  end

endmodule

// File: rtl/cmd_frontend.sv
// Per-source command FIFOs, round-robin merge into one show-ahead output, and
// in-order completion routing back to the issuing source.
module cmd_frontend
  import cmd_frontend_pkg::*;
#(
  parameter int SRC_COUNT = 2,
  parameter int DEPTH     = 8,
  parameter int INFLIGHT  = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rstn,
  input  logic [SRC_COUNT-1:0]          i_push,
  input  cmd_t [SRC_COUNT-1:0]          i_cmd,
  output logic [SRC_COUNT-1:0]          o_full,
  output cmd_t                          o_cmd,
  output logic [src_w(SRC_COUNT)-1:0]   o_src,
  output logic                          o_empty,
  input  logic                          i_rd,
  input  logic                          i_finished_task,
  output logic [SRC_COUNT-1:0]          o_done,
  output logic                          o_busy,
  output logic                          o_err
);
  localparam int SW  = src_w(SRC_COUNT);
  localparam int CW  = $clog2(DEPTH+1);
  localparam int TCW = $clog2(INFLIGHT+1);

  logic [SRC_COUNT-1:0]          src_empty, src_pop;
  cmd_t [SRC_COUNT-1:0]          src_head;
  logic [SRC_COUNT-1:0][CW-1:0]  src_cnt;

  for (genvar k = 0; k < SRC_COUNT; k++) begin : g_src
    sync_fifo #(.WIDTH($bits(cmd_t)), .DEPTH(DEPTH)) u_fifo (
      .i_clk   (i_clk),
      .i_rstn  (i_rstn),
      .i_push  (i_push[k]),
      .i_data  (i_cmd[k]),
      .i_pop   (src_pop[k]),
      .o_data  (src_head[k]),
      .o_full  (o_full[k]),
      .o_empty (src_empty[k]),
      .o_count (src_cnt[k])
    );
  end

  cmd_t            out_cmd_q;
  logic [SW-1:0]   out_src_q, rr_q, rr_d, gnt_idx;
  logic            out_vld_q, gnt_vld, pop, load, slot_ok, fin_ok, src_any;
  logic [SW-1:0]   tag_head;
  logic [TCW-1:0]  tag_cnt;
  logic            tag_full, tag_empty;
  logic [SRC_COUNT-1:0] done_q, done_d;
  logic            err_q;
  logic [CF_ERR_W-1:0] err_ev;
  int              idx;

  assign pop    = i_rd && out_vld_q;
  assign fin_ok = i_finished_task && !tag_empty;

  sync_fifo #(.WIDTH(SW), .DEPTH(INFLIGHT)) u_tag (
    .i_clk   (i_clk),
    .i_rstn  (i_rstn),
    .i_push  (pop),
    .i_data  (out_src_q),
    .i_pop   (fin_ok),
    .o_data  (tag_head),
    .o_full  (tag_full),
    .o_empty (tag_empty),
    .o_count (tag_cnt)
  );

  // First non-empty source at or after the round-robin pointer.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int i = 0; i < SRC_COUNT; i++) begin
      idx = int'(rr_q) + i;
      if (idx >= SRC_COUNT) idx = idx - SRC_COUNT;
      if (!gnt_vld && !src_empty[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = SW'(idx);
      end
    end
    rr_d = (gnt_idx == SW'(SRC_COUNT-1)) ? '0 : gnt_idx + 1'b1;
  end

  // The presented command reserves a tag slot, so a load is allowed only if the
  // tag FIFO will still have room after this cycle's pop/finish.
  always_comb begin
    if (fin_ok)   slot_ok = 1'b1;
    else if (pop) slot_ok = (int'(tag_cnt) < INFLIGHT-1);
    else          slot_ok = !tag_full;
  end

  assign load = (!out_vld_q || pop) && gnt_vld && slot_ok;

  always_comb begin
    src_pop = '0;
    done_d  = '0;
    src_any = 1'b0;
    for (int k = 0; k < SRC_COUNT; k++) begin
      src_pop[k] = load && (gnt_idx == SW'(k));
      done_d[k]  = fin_ok && (tag_head == SW'(k));
      if (src_cnt[k] != '0) src_any = 1'b1;
    end
  end

  always_comb begin
    err_ev = '0;
    err_ev[CF_ERR_PUSH_FULL] = |(i_push & o_full);
    err_ev[CF_ERR_RD_EMPTY]  = i_rd && !out_vld_q;
    err_ev[CF_ERR_FIN_EMPTY] = i_finished_task && tag_empty;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      out_cmd_q <= '0;
      out_src_q <= '0;
      out_vld_q <= 1'b0;
      rr_q      <= '0;
      done_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      if (load) begin
        out_cmd_q <= src_head[gnt_idx];
        out_src_q <= gnt_idx;
        out_vld_q <= 1'b1;
        rr_q      <= rr_d;
      end else if (pop) begin
        out_vld_q <= 1'b0;
      end
      done_q <= done_d;
      err_q  <= err_q | (|err_ev);
    end
  end

  assign o_cmd   = out_cmd_q;
  assign o_src   = out_src_q;
  assign o_empty = !out_vld_q;
  assign o_done  = done_q;
  assign o_err   = err_q;
  assign o_busy  = src_any || out_vld_q || !tag_empty;

endmodule

// File: tb/tb_cmd_frontend.sv
// Directed bench for cmd_frontend (SRC_COUNT=2, DEPTH=8, INFLIGHT=4).
module tb_cmd_frontend;
  import cmd_frontend_pkg::*;

  logic       clk = 1'b0;
  logic       rstn;
  logic [1:0] push;
  cmd_t [1:0] cmd_in;
  logic [1:0] full;
  cmd_t       cmd_out;
  logic [0:0] src;
  logic       empty, rd, fin, busy, err;
  logic [1:0] done;

  cmd_frontend #(.SRC_COUNT(2), .DEPTH(8), .INFLIGHT(4)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_push(push), .i_cmd(cmd_in), .o_full(full),
    .o_cmd(cmd_out), .o_src(src), .o_empty(empty), .i_rd(rd),
    .i_finished_task(fin), .o_done(done), .o_busy(busy), .o_err(err)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  logic [31:0] exp_cmd [$];
  int          exp_src [$];
  int          fly_q   [$];
  logic [1:0]  done_exp;
  int          bubbles;
  bit          started;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0; push = '0; cmd_in = '0; rd = 1'b0; fin = 1'b0;
    exp_cmd.delete(); exp_src.delete(); fly_q.delete(); done_exp = '0;
    repeat (2) tick();
    rstn = 1'b1;
    tick();
    chk("rst_full", 64'(full), 0);
    chk("rst_empty", 64'(empty), 1);
    chk("rst_cmd", 64'(cmd_out), 0);
    chk("rst_src", 64'(src), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_err", 64'(err), 0);
  endtask

  // One cycle: checks last cycle's done prediction, pops/finishes as permitted, advances.
  task automatic step(input logic [1:0] p, input logic [31:0] c0, input logic [31:0] c1,
                      input bit do_rd, input bit do_fin);
    int s;
    chk("done", 64'(done), 64'(done_exp));
    push = p; cmd_in[0] = cmd_t'(c0); cmd_in[1] = cmd_t'(c1);
    rd = do_rd && !empty;
    fin = do_fin && (fly_q.size() > 0);
    done_exp = '0;
    if (fin) begin
      s = fly_q.pop_front();
      done_exp[s] = 1'b1;
    end
    if (rd) begin
      if (exp_cmd.size() > 0) begin
        chk("pop_cmd", 64'(cmd_out), 64'(exp_cmd.pop_front()));
        s = exp_src.pop_front();
        chk("pop_src", 64'(src), 64'(s));
      end else begin
        chk("extra_pop", 64'(exp_cmd.size()), 1);
      end
      fly_q.push_back(int'(src));
    end
    tick();
    push = '0; rd = 1'b0; fin = 1'b0;
  endtask

  task automatic expect_push(input logic [31:0] c, input int s);
    exp_cmd.push_back(c);
    exp_src.push_back(s);
  endtask

  task automatic drain();
    int cyc = 0;
    while ((busy || fly_q.size() > 0) && cyc < 80) begin
      step(2'b00, 0, 0, 1'b1, 1'b1);
      cyc++;
    end
    chk("drain_timeout", 64'(cyc < 80), 1);
    step(2'b00, 0, 0, 1'b0, 1'b0);
    chk("drain_left", 64'(exp_cmd.size()), 0);
    chk("drain_busy", 64'(busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Single command: presented two cycles after push, done one cycle after finish.
    do_reset();
    expect_push(32'hA000_0001, 0);
    step(2'b01, 32'hA000_0001, 0, 1'b0, 1'b0);
    chk("t1_empty_t1", 64'(empty), 1);
    step(2'b00, 0, 0, 1'b0, 1'b0);
    chk("t1_empty_t2", 64'(empty), 0);
    chk("t1_cmd", 64'(cmd_out), 64'h A000_0001);
    chk("t1_busy", 64'(busy), 1);
    step(2'b00, 0, 0, 1'b1, 1'b0);
    chk("t1_empty_after_pop", 64'(empty), 1);
    step(2'b00, 0, 0, 1'b0, 1'b1);
    chk("t1_done", 64'(done), 2'b01);
    step(2'b00, 0, 0, 1'b0, 1'b0);
    chk("t1_done_clr", 64'(done), 0);
    chk("t1_err", 64'(err), 0);

    // Two sources, alternating issue, no bubble once started.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      expect_push(32'h100 + i, 0);
      expect_push(32'h200 + i, 1);
    end
    bubbles = 0; started = 0;
    for (int i = 0; i < 16; i++) begin
      if (!empty) started = 1;
      if (started && empty && exp_cmd.size() > 0) bubbles++;
      if (i < 4) step(2'b11, 32'h100 + i, 32'h200 + i, 1'b1, 1'b1);
      else       step(2'b00, 0, 0, 1'b1, 1'b1);
    end
    chk("t2_bubbles", 64'(bubbles), 0);
    chk("t2_started", 64'(started), 1);
    drain();
    chk("t2_err", 64'(err), 0);

    // In-flight limit: four pops with no finish stall the output.
    do_reset();
    for (int i = 0; i < 4; i++) expect_push(32'h300 + i, 0);
    for (int i = 0; i < 6; i++) step(2'b01, 32'h300 + i, 0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(2'b00, 0, 0, 1'b1, 1'b0);
    chk("t3_stall_empty", 64'(empty), 1);
    chk("t3_stall_busy", 64'(busy), 1);
    chk("t3_inflight", 64'(fly_q.size()), 4);

    // Overflow src 1 while the output is stalled: full after 8th, 9th dropped.
    for (int i = 0; i < 9; i++) begin
      step(2'b10, 0, 32'h400 + i, 1'b1, 1'b0);
      chk("t4_full", 64'(full[1]), 64'(i >= 7));
      chk("t4_err", 64'(err), 64'(i == 8));
      chk("t4_empty", 64'(empty), 1);
    end
    // One finish frees a slot; src 1 is next in round-robin order.
    step(2'b00, 0, 0, 1'b0, 1'b1);
    chk("t3_resume_empty", 64'(empty), 0);
    chk("t3_resume_cmd", 64'(cmd_out), 32'h400);
    chk("t3_resume_src", 64'(src), 1);
    expect_push(32'h400, 1); expect_push(32'h304, 0);
    expect_push(32'h401, 1); expect_push(32'h305, 0);
    for (int i = 2; i < 8; i++) expect_push(32'h400 + i, 1);
    drain();
    chk("t4_err_sticky", 64'(err), 1);

    // Protocol errors: read while empty, finish with nothing in flight.
    do_reset();
    rd = 1'b1; tick(); rd = 1'b0;
    chk("t5_rd_err", 64'(err), 1);
    chk("t5_rd_empty", 64'(empty), 1);
    chk("t5_rd_busy", 64'(busy), 0);
    do_reset();
    fin = 1'b1; tick(); fin = 1'b0;
    chk("t5_fin_err", 64'(err), 1);
    chk("t5_fin_done0", 64'(done), 0);
    tick();
    chk("t5_fin_done1", 64'(done), 0);

    // Reset mid-operation: 3 queued, 2 in flight.
    do_reset();
    expect_push(32'h500, 0); expect_push(32'h501, 0);
    for (int i = 0; i < 5; i++) step(2'b01, 32'h500 + i, 0, i < 4, 1'b0);
    chk("t6_pre_inflight", 64'(fly_q.size()), 2);
    chk("t6_pre_empty", 64'(empty), 0);
    rstn = 1'b0;
    #1;
    chk("t6_rst_empty", 64'(empty), 1);
    chk("t6_rst_busy", 64'(busy), 0);
    chk("t6_rst_cmd", 64'(cmd_out), 0);
    chk("t6_rst_full", 64'(full), 0);
    chk("t6_rst_done", 64'(done), 0);
    @(negedge clk);
    rstn = 1'b1;
    tick();
    fin = 1'b1; tick();
    chk("t6_fin_done_a", 64'(done), 0);
    tick(); fin = 1'b0;
    chk("t6_fin_done_b", 64'(done), 0);
    tick();
    chk("t6_fin_done_c", 64'(done), 0);
    chk("t6_err", 64'(err), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
